key_hit_scheduler: RTL

//  Pops the keypoint buffer at the right moment. It tracks the raster (x,y) of the incoming pixel stream and

---
 rtl/key_hit_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/key_hit_scheduler.sv
// key_hit_scheduler: pops the keypoint buffer once the BRIEF window of its head keypoint is fully buffered.
//   Tracks the raster position of the pixel stream, compares it with the target derived from the
//   buffer head, and pulses o_hit / o_kp_valid with the popped keypoint. At end of frame it flushes
//   keypoints that never matured.
//   in : i_clk, i_rst_n (sync, active-low), i_valid, i_frame_start, i_head_* (buffer head, score 0 = empty)
//   out: o_hit (pop request), o_kp_valid + o_kp_* (popped keypoint), o_frame_done, o_err (sticky)
module key_hit_scheduler #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int OFF_X = 16,
  parameter int OFF_Y = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_frame_start,
  input  logic [9:0]  i_head_coor_x,
  input  logic [9:0]  i_head_coor_y,
  input  logic [7:0]  i_head_score,
  input  logic [11:0] i_head_sin,
  input  logic [11:0] i_head_cos,
  input  logic [9:0]  i_head_depth,
  output logic        o_hit,
  output logic        o_kp_valid,
  output logic [9:0]  o_kp_coor_x,
  output logic [9:0]  o_kp_coor_y,
  output logic [11:0] o_kp_sin,
  output logic [11:0] o_kp_cos,
  output logic [7:0]  o_kp_score,
  output logic [9:0]  o_kp_depth,
  output logic        o_frame_done,
  output logic        o_err
);
  typedef enum logic [1:0] {IDLE, WAIT, COOL, FLUSH} state_t;
  localparam logic [9:0] X_MAX = 10'(IMG_W - 1);
  localparam logic [9:0] Y_MAX = 10'(IMG_H - 1);
  state_t      state;
  logic [9:0]  nx, ny;
  logic        gap;
  logic        sof, head_valid, reached, last;
  logic [9:0]  cx, cy;
  logic [10:0] tx, ty;
  // nx/ny hold the position the next accepted pixel will take unless it starts a frame.
  always_comb begin
    sof        = i_valid & i_frame_start;
    cx         = sof ? '0 : nx;
    cy         = sof ? '0 : ny;
    tx         = {1'b0, i_head_coor_x} + 11'(OFF_X);
    ty         = {1'b0, i_head_coor_y} + 11'(OFF_Y);
    head_valid = |i_head_score;
    reached    = i_valid & (({1'b0, cy} > ty) | (({1'b0, cy} == ty) & ({1'b0, cx} >= tx)));
    last       = i_valid & (cx == X_MAX) & (cy == Y_MAX);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      nx           <= '0;
      ny           <= '0;
      gap          <= 1'b0;
      o_hit        <= 1'b0;
      o_kp_valid   <= 1'b0;
      o_kp_coor_x  <= '0;
      o_kp_coor_y  <= '0;
      o_kp_sin     <= '0;
      o_kp_cos     <= '0;
      o_kp_score   <= '0;
      o_kp_depth   <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_hit        <= 1'b0;
      o_kp_valid   <= 1'b0;
      o_frame_done <= last;
      if (i_valid) begin
        nx <= (cx == X_MAX) ? '0 : cx + 10'd1;
        ny <= (cx != X_MAX) ? cy : (cy == Y_MAX) ? '0 : cy + 10'd1;
      end
      if (sof && state == FLUSH) o_err <= 1'b1;
      // End of frame wins over a hit maturing on the same pixel.
      if (last && state != FLUSH) begin
        state <= FLUSH;
        gap   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= head_valid ? WAIT : IDLE;
          WAIT: begin
            if (!head_valid) state <= IDLE;
            else if (reached) begin
              o_hit       <= 1'b1;
              o_kp_valid  <= 1'b1;
              o_kp_coor_x <= i_head_coor_x;
              o_kp_coor_y <= i_head_coor_y;
              o_kp_sin    <= i_head_sin;
              o_kp_cos    <= i_head_cos;
              o_kp_score  <= i_head_score;
              o_kp_depth  <= i_head_depth;
              state       <= COOL;
            end
          end
          // o_hit is visible this cycle; the head seen here is the one being popped.
          COOL: state <= head_valid ? WAIT : IDLE;
          // gap marks the cycle o_hit is visible, when the head is still the stale one.
          FLUSH: begin
            if (gap) gap <= 1'b0;
            else if (head_valid) begin
              o_hit <= 1'b1;
              gap   <= 1'b1;
            end else state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
